// File: rtl/tow_pkg.sv
// Shared definitions for the round referee: FSM states, winner encodings and
// the default winner-hold length.
package tow_pkg;

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_WIN_L   = 2'd1,
    ST_WIN_R   = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;

  localparam int HOLD_CYCLES_DEFAULT = 16;
  localparam int HOLD_W              = 8;

  function automatic logic [1:0] winner_of(input state_t st);
    logic [1:0] w;
    case (st)
      ST_WIN_L: w = WINNER_LEFT;
      ST_WIN_R: w = WINNER_RIGHT;
      ST_PLAY:  w = WINNER_NONE;
      default:  w = WINNER_NONE;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/key_pulse.sv
// Two-flop synchronizer for a raw key level plus a registered edge history;
// rise is high while the synced level is 1 and its history is still 0.
module key_pulse (
  input  logic Clock,
  input  logic reset,
  input  logic key,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchronizer chain and edge history
  always_ff @(posedge Clock) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/round_referee.sv
// Tug-of-war round referee: forwards key presses to the playfield, detects a
// winning press at an end light, holds the winner, then restarts the round.
module round_referee
  import tow_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       keyL,
  input  logic       keyR,
  input  logic       leftEnd,
  input  logic       rightEnd,
  output logic       pressL,
  output logic       pressR,
  output logic       victoryL,
  output logic       victoryR,
  output logic       roundReset,
  output logic [1:0] winner
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t              state_r;
  state_t              state_s;
  logic [HOLD_W-1:0]   hold_r;
  logic [HOLD_W-1:0]   hold_s;
  logic                rise_l_s;
  logic                rise_r_s;
  logic                win_l_s;
  logic                win_r_s;
  logic                press_l_s;
  logic                press_r_s;

  key_pulse u_key_l (
    .Clock (Clock),
    .reset (reset),
    .key   (keyL),
    .rise  (rise_l_s)
  );

  key_pulse u_key_r (
    .Clock (Clock),
    .reset (reset),
    .key   (keyR),
    .rise  (rise_r_s)
  );

  // Next-state, hold counter and press forwarding; presses only leave in PLAY
  always_comb begin
    state_s   = state_r;
    hold_s    = hold_r;
    win_l_s   = 1'b0;
    win_r_s   = 1'b0;
    press_l_s = 1'b0;
    press_r_s = 1'b0;
    case (state_r)
      ST_PLAY: begin
        // Both ends lit, or both keys rising together, is never a win
        win_l_s   = rise_l_s & ~rise_r_s & leftEnd & ~rightEnd;
        win_r_s   = rise_r_s & ~rise_l_s & rightEnd & ~leftEnd;
        press_l_s = rise_l_s & ~win_l_s;
        press_r_s = rise_r_s & ~win_r_s;
        hold_s    = {HOLD_W{1'b0}};
        if (win_l_s) begin
          state_s = ST_WIN_L;
        end else if (win_r_s) begin
          state_s = ST_WIN_R;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_WIN_L, ST_WIN_R: begin
        if (hold_r == HOLD_LAST) begin
          state_s = ST_RESTART;
          hold_s  = {HOLD_W{1'b0}};
        end else begin
          state_s = state_r;
          hold_s  = hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESTART: begin
        state_s = ST_PLAY;
        hold_s  = {HOLD_W{1'b0}};
      end
      default: begin
        state_s = ST_RESTART;
        hold_s  = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State, hold counter and registered pulse outputs
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_r  <= ST_RESTART;
      hold_r   <= {HOLD_W{1'b0}};
      pressL   <= 1'b0;
      pressR   <= 1'b0;
      victoryL <= 1'b0;
      victoryR <= 1'b0;
    end else begin
      state_r  <= state_s;
      hold_r   <= hold_s;
      pressL   <= press_l_s;
      pressR   <= press_r_s;
      victoryL <= win_l_s;
      victoryR <= win_r_s;
    end
  end

  assign winner     = winner_of(state_r);
  assign roundReset = (state_r == ST_RESTART);

endmodule

// File: doc/round_referee.md
ROUND_REFEREE -- requirements
Module: round_referee

Interface
REQ-001 Parameter HOLD_CYCLES, default 16, meaning: number of cycles the winner is held before the playfield restarts; legal range 1..255.
REQ-002 Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 keyL  input  1  raw asynchronous left-player key level, 1 = pressed.
REQ-005 keyR  input  1  raw asynchronous right-player key level, 1 = pressed.
REQ-006 leftEnd  input  1  leftmost playfield light is on.
REQ-007 rightEnd  input  1  rightmost playfield light is on.
REQ-008 pressL  output  1  registered single-cycle left press pulse to the playfield.
REQ-009 pressR  output  1  registered single-cycle right press pulse to the playfield.
REQ-010 victoryL  output  1  registered single-cycle pulse to the left player's 3-bit win counter's victory input.
REQ-011 victoryR  output  1  registered single-cycle pulse to the right player's 3-bit win counter's victory input.
REQ-012 roundReset  output  1  playfield reset, high for exactly one cycle per round restart.
REQ-013 winner  output  2  00 none, 01 left, 10 right; 11 never driven.

Function
REQ-014 Each key SHALL pass a 2-flop synchronizer followed by a rising-edge detector; a press is one synced 0->1 transition.
REQ-015 Press latency SHALL be fixed: pressL/pressR high in the cycle after the 3rd rising Clock edge at which the raw key is sampled high, for exactly one cycle.
REQ-016 A key held high SHALL produce exactly one press; a new press requires the synced level to return to 0 for at least one cycle.
REQ-017 FSM states SHALL be PLAY, WIN_L, WIN_R, RESTART.
REQ-018 In PLAY, press pulses SHALL be forwarded; in WIN_L, WIN_R, RESTART, pressL/pressR SHALL be forced 0 while edge-detector history continues to track.
REQ-019 PLAY->WIN_L when an internal left press occurs with leftEnd=1, rightEnd=0, and no simultaneous right press; PLAY->WIN_R symmetric.
REQ-020 Simultaneous left and right presses SHALL cause no win and SHALL both be forwarded.
REQ-021 leftEnd=1 and rightEnd=1 together SHALL be treated as no win.
REQ-022 The winning press SHALL NOT be forwarded to the playfield.
REQ-023 victoryL (victoryR) SHALL be high for exactly the first cycle in WIN_L (WIN_R); exactly one victory pulse per round.
REQ-024 winner SHALL read 01 throughout WIN_L, 10 throughout WIN_R, and 00 in PLAY and RESTART.
REQ-025 A hold counter SHALL keep the FSM in WIN_L/WIN_R for exactly HOLD_CYCLES cycles, then move to RESTART.
REQ-026 RESTART SHALL last exactly one cycle with roundReset=1, then go to PLAY; roundReset=0 in all other states.
REQ-027 End-light inputs SHALL be ignored outside PLAY.

Reset
REQ-028 On reset, FSM SHALL go to RESTART; hold counter, synchronizers and edge history SHALL clear to 0.
REQ-029 Reset values: pressL=pressR=victoryL=victoryR=0, winner=00, roundReset=1.
REQ-030 Reset asserted mid-hold or mid-RESTART SHALL abort the round with no victory pulse; the first cycle after release SHALL be RESTART.

Structure
REQ-031 Package tow_pkg SHALL hold the FSM state enum, winner encoding constants, and HOLD_CYCLES default.
REQ-032 Sub-module key_pulse (synchronizer plus registered edge detector) SHALL be instantiated once per key.
REQ-033 Outputs SHALL be registered or Moore-decoded from the state register; no input-to-output combinational path.

Verification (HOLD_CYCLES=4)
REQ-034 Reset, release -> roundReset=1 for one cycle after release, then 0; winner=00.
REQ-035 keyL high 10 cycles in PLAY, ends off -> one pressL pulse, 3 cycles after first sample; no victory.
REQ-036 leftEnd=1, keyL rising -> no pressL; victoryL=1 one cycle; winner=01 for 4 cycles; roundReset one cycle; then PLAY, winner=00.
REQ-037 leftEnd=1, keyL and keyR rising same cycle -> pressL and pressR both pulse; no victory; stays PLAY.
REQ-038 keyR held through WIN_R and RESTART -> no pressR after return to PLAY until keyR released and re-pressed.
REQ-039 Reset asserted at hold cycle 2 of WIN_L -> no further victory pulse, winner=00, roundReset the cycle after release.
